// File: rtl/maxnet_iterator.sv
// Iterative MaxNet winner-take-all engine: four activations inhibit each other once per clock
// until the downstream combinational decoder reports a single survivor, all decay to zero, or the limit hits.
module maxnet_iterator #(
    parameter int unsigned W         = 5,
    parameter int unsigned EPS_SHIFT = 3,
    parameter int unsigned MAX_ITER  = 63,
    parameter int unsigned ITER_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      x1,
    input  logic [W-1:0]      x2,
    input  logic [W-1:0]      x3,
    input  logic [W-1:0]      x4,
    output logic [W-1:0]      a1,
    output logic [W-1:0]      a2,
    output logic [W-1:0]      a3,
    output logic [W-1:0]      a4,
    input  logic              dec_done,
    input  logic [1:0]        dec_idx,
    output logic              busy,
    output logic              result_valid,
    output logic [1:0]        winner_idx,
    output logic              no_winner,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count,
    input  logic              ack
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [W-1:0]        r_a [4];
    logic [1:0]          r_winner;
    logic                r_no_winner;
    logic                r_timeout;
    logic [ITER_W-1:0]   r_iter;

    logic [W-1:0]        w_x     [4];
    logic [W-1:0]        w_a_upd [4];
    logic [W+1:0]        w_sum   [4];
    logic [W+1:0]        w_inh   [4];
    logic [W+1:0]        w_total;
    logic                w_all_zero;
    logic                w_at_limit;

    assign w_x[0] = x1;
    assign w_x[1] = x2;
    assign w_x[2] = x3;
    assign w_x[3] = x4;

    // Sum of the other three is total minus self; W+2 bits holds 4*(2^W-1) without overflow.
    always_comb begin
        w_total    = {2'b00, r_a[0]} + {2'b00, r_a[1]} + {2'b00, r_a[2]} + {2'b00, r_a[3]};
        w_all_zero = (w_total == '0);
        w_at_limit = (r_iter == ITER_W'(MAX_ITER));
        for (int unsigned i = 0; i < 4; i++) begin
            w_sum[i] = w_total - {2'b00, r_a[i]};
            w_inh[i] = w_sum[i] >> EPS_SHIFT;
            if ((w_sum[i] != '0) && (w_inh[i] == '0))
                w_inh[i] = (W+2)'(1);
            w_a_upd[i] = ({2'b00, r_a[i]} > w_inh[i]) ? (r_a[i] - w_inh[i][W-1:0]) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_ITER;
            S_ITER: if (dec_done || w_all_zero || w_at_limit) w_state_nxt = S_DONE;
            S_DONE: if (ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) r_a[i] <= '0;
            r_winner    <= '0;
            r_no_winner <= 1'b0;
            r_timeout   <= 1'b0;
            r_iter      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < 4; i++) r_a[i] <= w_x[i];
                        r_winner    <= '0;
                        r_no_winner <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_iter      <= '0;
                    end
                end
                S_ITER: begin
                    if (dec_done) begin
                        r_winner <= dec_idx;
                    end else if (w_all_zero) begin
                        r_no_winner <= 1'b1;
                    end else if (w_at_limit) begin
                        r_timeout <= 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < 4; i++) r_a[i] <= w_a_upd[i];
                        r_iter <= r_iter + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign a1           = r_a[0];
    assign a2           = r_a[1];
    assign a3           = r_a[2];
    assign a4           = r_a[3];
    assign busy         = (r_state == S_ITER);
    assign result_valid = (r_state == S_DONE);
    assign winner_idx   = r_winner;
    assign no_winner    = r_no_winner;
    assign timeout      = r_timeout;
    assign iter_count   = r_iter;

endmodule

// File: tb/tb_maxnet_iterator.sv
// Directed bench for maxnet_iterator with a behavioural decoder model closing the loop;
// a second instance with a short iteration limit covers the timeout path.
module tb_maxnet_iterator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, ack = 1'b0;
    logic       start_t = 1'b0, ack_t = 1'b0;
    logic [4:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;

    logic [4:0] a1, a2, a3, a4, t1, t2, t3, t4;
    logic       dec_done, dec_done_t;
    logic [1:0] dec_idx, dec_idx_t;
    logic       busy, result_valid, no_winner, timeout;
    logic       busy_t, rv_t, nw_t, to_t;
    logic [1:0] winner_idx, win_t;
    logic [5:0] iter_count, it_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maxnet_iterator #(.W(5), .EPS_SHIFT(3), .MAX_ITER(63), .ITER_W(6)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .dec_done(dec_done), .dec_idx(dec_idx),
        .busy(busy), .result_valid(result_valid), .winner_idx(winner_idx),
        .no_winner(no_winner), .timeout(timeout), .iter_count(iter_count), .ack(ack)
    );

    maxnet_iterator #(.W(5), .EPS_SHIFT(3), .MAX_ITER(3), .ITER_W(6)) dut_t (
        .clk(clk), .rst(rst), .start(start_t),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .a1(t1), .a2(t2), .a3(t3), .a4(t4),
        .dec_done(dec_done_t), .dec_idx(dec_idx_t),
        .busy(busy_t), .result_valid(rv_t), .winner_idx(win_t),
        .no_winner(nw_t), .timeout(to_t), .iter_count(it_t), .ack(ack_t)
    );

    // Decoder model: done when exactly one input is nonzero, idx is that input.
    function automatic logic [2:0] decode(input logic [4:0] p, q, r, s);
        int n = 0;
        logic [1:0] id = 2'd0;
        if (s != 0) begin n++; id = 2'd3; end
        if (r != 0) begin n++; id = 2'd2; end
        if (q != 0) begin n++; id = 2'd1; end
        if (p != 0) begin n++; id = 2'd0; end
        return {(n == 1), id};
    endfunction

    always_comb {dec_done, dec_idx}     = decode(a1, a2, a3, a4);
    always_comb {dec_done_t, dec_idx_t} = decode(t1, t2, t3, t4);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start_run(input int v1, v2, v3, v4);
        @(negedge clk);
        x1 = 5'(v1); x2 = 5'(v2); x3 = 5'(v3); x4 = 5'(v4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges from the start edge (which counts as 1) until result_valid is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!result_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!result_valid) chk("wait_done", 0, 1);
    endtask

    task automatic do_ack;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_rv", int'(result_valid), 0);
    endtask

    task automatic chk_normal(input string tag);
        chk({tag, "_rv"}, int'(result_valid), 1);
        chk({tag, "_win"}, int'(winner_idx), 0);
        chk({tag, "_iter"}, int'(iter_count), 5);
        chk({tag, "_a1"}, int'(a1), 14);
        chk({tag, "_nw"}, int'(no_winner), 0);
        chk({tag, "_to"}, int'(timeout), 0);
    endtask

    typedef struct {
        int x1, x2, x3, x4;
        int e1, e2, e3, e4;
        int ewin, enw, eit;
    } vec_t;

    vec_t vecs[6];
    int   cyc;

    initial begin
        vecs[0] = '{20, 10, 5, 2,  14, 0, 0, 0,   0, 0, 5};
        vecs[1] = '{10, 10, 0, 0,   0, 0, 0, 0,   0, 1, 10};
        vecs[2] = '{0, 0, 7, 0,     0, 0, 7, 0,   2, 0, 0};
        vecs[3] = '{0, 0, 0, 0,     0, 0, 0, 0,   0, 1, 0};
        vecs[4] = '{0, 3, 9, 0,     0, 0, 6, 0,   2, 0, 3};
        vecs[5] = '{31, 31, 31, 31, 0, 0, 0, 0,   0, 1, 9};

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rv", int'(result_valid), 0);
        chk("rst_a", int'({a1, a2, a3, a4}), 0);
        chk("rst_iter", int'(iter_count), 0);
        chk("rst_flags", int'({no_winner, timeout, winner_idx}), 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            start_run(vecs[k].x1, vecs[k].x2, vecs[k].x3, vecs[k].x4);
            chk($sformatf("v%0d_busy", k), int'(busy), 1);
            wait_done(cyc);
            chk($sformatf("v%0d_lat", k), cyc, vecs[k].eit + 2);
            chk($sformatf("v%0d_a1", k), int'(a1), vecs[k].e1);
            chk($sformatf("v%0d_a2", k), int'(a2), vecs[k].e2);
            chk($sformatf("v%0d_a3", k), int'(a3), vecs[k].e3);
            chk($sformatf("v%0d_a4", k), int'(a4), vecs[k].e4);
            chk($sformatf("v%0d_win", k), int'(winner_idx), vecs[k].ewin);
            chk($sformatf("v%0d_nw", k), int'(no_winner), vecs[k].enw);
            chk($sformatf("v%0d_to", k), int'(timeout), 0);
            chk($sformatf("v%0d_iter", k), int'(iter_count), vecs[k].eit);
            chk($sformatf("v%0d_busy_done", k), int'(busy), 0);
            do_ack();
        end

        // Timeout instance: limit of 3 updates.
        @(negedge clk);
        x1 = 5'd20; x2 = 5'd10; x3 = 5'd5; x4 = 5'd2;
        start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        cyc = 1;
        while (!rv_t && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_lat", cyc, 5);
        chk("to_flag", int'(to_t), 1);
        chk("to_nw", int'(nw_t), 0);
        chk("to_iter", int'(it_t), 3);
        chk("to_a", int'({t1, t2, t3, t4}), int'({5'd16, 5'd3, 5'd0, 5'd0}));
        ack_t = 1'b1;
        @(negedge clk);
        ack_t = 1'b0;
        chk("to_ack", int'(rv_t), 0);

        // Handshake: start and ack pulsed mid-ITER must be ignored.
        start_run(20, 10, 5, 2);
        @(negedge clk);
        x1 = 5'd0; x2 = 5'd0; x3 = 5'd7; x4 = 5'd0;
        start = 1'b1; ack = 1'b1;
        @(negedge clk);
        start = 1'b0; ack = 1'b0;
        wait_done(cyc);
        chk_normal("hs");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_normal($sformatf("hold%0d", i));
        end
        // ack and start together in DONE: ack wins, start is dropped.
        start = 1'b1; ack = 1'b1;
        @(negedge clk);
        start = 1'b0; ack = 1'b0;
        chk("hs_idle_rv", int'(result_valid), 0);
        chk("hs_idle_busy", int'(busy), 0);
        @(negedge clk);
        chk("hs_nostart_busy", int'(busy), 0);
        chk("hs_keep_iter", int'(iter_count), 5);
        start_run(0, 0, 7, 0);
        wait_done(cyc);
        chk("hs_fresh_win", int'(winner_idx), 2);
        chk("hs_fresh_iter", int'(iter_count), 0);
        do_ack();

        // Asynchronous reset between edges mid-ITER.
        start_run(20, 10, 5, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_a", int'({a1, a2, a3, a4}), 0);
        chk("arst_iter", int'(iter_count), 0);
        chk("arst_rv", int'(result_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        start_run(20, 10, 5, 2);
        wait_done(cyc);
        chk("arst_lat", cyc, 7);
        chk_normal("arst");
        do_ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/maxnet_iterator.md
Name: maxnet_iterator

Overview:
- Iterative winner-take-all (MaxNet) engine that sits directly upstream of the `decoder` block.
- Holds four unsigned activations and applies one mutual-inhibition update per clock.
- Drives the activations onto `decoder`'s A1..A4 inputs and samples `decoder`'s done/idx to stop and report the winner.
- Also stops and flags when no single winner can emerge: all activations zero, or the iteration limit is reached.

Parameters:
- W, 5, activation width; must match `decoder` input width.
- EPS_SHIFT, 3, inhibition weight = 2^-EPS_SHIFT, implemented as a right shift.
- MAX_ITER, 63, maximum update cycles before timeout.
- ITER_W, 6, iteration counter width; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  load x1..x4 and begin; honoured only in IDLE.
- x1, x2, x3, x4  in  W each  initial activations.
- a1, a2, a3, a4  out  W each  registered activations, wired to `decoder` A1..A4.
- dec_done  in  1  from `decoder`: exactly one of a1..a4 is nonzero.
- dec_idx  in  2  from `decoder`: index of the nonzero activation (0=a1 .. 3=a4).
- busy  out  1  high in ITER.
- result_valid  out  1  high in DONE.
- winner_idx  out  2  captured dec_idx; valid with result_valid.
- no_winner  out  1  all activations reached zero with no single survivor.
- timeout  out  1  MAX_ITER updates performed without convergence.
- iter_count  out  ITER_W  number of updates performed.
- ack  in  1  consumer acknowledge of result.

Behaviour:
- Reset (async, rst=1): state=IDLE. a1..a4, winner_idx, iter_count = 0. busy, result_valid, no_winner, timeout = 0.
- States: IDLE, ITER, DONE.
- IDLE, start=1 at an edge:
  - a_i <= x_i; iter_count <= 0.
  - Clear no_winner, timeout, winner_idx.
  - Go to ITER.
- ITER, evaluated at each edge in priority order:
  1. dec_done=1: winner_idx <= dec_idx; go to DONE; activations unchanged.
  2. All a_i = 0: no_winner <= 1; go to DONE.
  3. iter_count = MAX_ITER: timeout <= 1; go to DONE; activations unchanged.
  4. Otherwise, update all four activations simultaneously from current values (next bullet); iter_count++.
- Update rule, per activation i:
  - S_i = sum of the other three activations, computed at W+2 bits (no overflow).
  - inh_i = S_i >> EPS_SHIFT; if S_i != 0 and inh_i = 0, then inh_i = 1 (guarantees progress).
  - a_i <= (a_i > inh_i) ? a_i - inh_i : 0 (ReLU, no wrap).
- `decoder` is purely combinational. dec_done/dec_idx reflect the current a1..a4 and are sampled at the next edge.
  - A one-cycle path budget (≈13 gate delays) is sufficient.
  - Convergence is therefore seen one cycle after the final update.
- DONE:
  - result_valid=1; winner_idx, no_winner, timeout, iter_count and a1..a4 held stable.
  - ack=1 at an edge: go to IDLE, result_valid <= 0. Flags keep their values until the next start.
- start while in ITER or DONE is ignored.
- ack outside DONE is ignored.
- start and ack in the same DONE cycle: ack wins; start is not captured and must be reissued in IDLE.
- rst mid-ITER or mid-DONE: immediate return to reset values; no result is reported.
- Exact ties between maxima decay symmetrically to zero and end with no_winner=1; this is deterministic, not an error.

Test Plan (W=5, EPS_SHIFT=3):
- Normal convergence: start with x=20,10,5,2.
  - Successive updates: (18,7,1,0), (17,5,0,0), (16,3,0,0), (15,1,0,0), (14,0,0,0).
  - Required: result_valid rises at the edge after the 5th update; winner_idx=0, iter_count=5, no_winner=0, timeout=0, a1=14.
- Already resolved: x=0,0,7,0 -> DONE after first ITER edge; winner_idx=2, iter_count=0, a3=7.
- Tie: x=10,10,0,0 -> a1=a2 decrement by 1 per cycle to 0; no_winner=1, iter_count=10, result_valid=1. All-zero input x=0,0,0,0 -> no_winner=1, iter_count=0.
- Timeout: MAX_ITER=3, x=20,10,5,2 -> timeout=1, iter_count=3, a=(16,3,0,0), result_valid=1.
- Handshake: hold ack=0 for 5 cycles in DONE -> all outputs stable. Pulse start during ITER -> no reload. Assert ack -> IDLE next edge. New start -> fresh run, flags cleared.
- Reset: assert rst asynchronously mid-ITER (between edges) -> all outputs 0 immediately; after release, a start with x=20,10,5,2 reproduces the normal-convergence result.
